lcd_hd44780_responder: RTL and testbench

//  Device side of the 8-bit HD44780 parallel bus: samples EN/RS/RW/DATA driven by the LCD writer, decodes

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_ddram.sv | 30 +++
 rtl/lcd_hd44780_responder.sv | 215 +++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and address-counter helpers for the
// HD44780 bus responder.
package lcd_pkg;

  localparam int unsigned DDRAM_DEPTH = 80;
  localparam int unsigned LINE_LEN    = 40;
  localparam logic [6:0]  LINE2_BASE  = 7'h40;
  localparam logic [6:0]  LINE1_LAST  = 7'h27;
  localparam logic [6:0]  LINE2_LAST  = 7'h67;
  localparam logic [7:0]  CHAR_SPACE  = 8'h20;

  // Instruction opcode masks; the highest set bit selects the instruction.
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISPLAY   = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic [1:0] {StClear, StIdle, StDecode, StBusy} lcd_state_e;

  // AC values that map onto a DDRAM cell.
  function automatic logic ac_valid(input logic [6:0] ac);
    return (ac <= LINE1_LAST) || ((ac >= LINE2_BASE) && (ac <= LINE2_LAST));
  endfunction

  // Linear DDRAM index for a valid AC: line 2 follows line 1.
  function automatic logic [6:0] ac_index(input logic [6:0] ac);
    return (ac >= LINE2_BASE) ? (ac - LINE2_BASE + 7'(LINE_LEN)) : ac;
  endfunction

  // One AC step with wrap between the two line windows.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == LINE1_LAST)      return LINE2_BASE;
      else if (ac == LINE2_LAST) return 7'h00;
      else                       return ac + 7'd1;
    end else begin
      if (ac == 7'h00)           return LINE2_LAST;
      else if (ac == LINE2_BASE) return LINE1_LAST;
      else                       return ac - 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one synchronous write port, one synchronous read
// port for the display side and one asynchronous read port for bus readback.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clock,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic [6:0] ar_addr,
  output logic [7:0] ar_data
);

  logic [7:0] mem [DDRAM_DEPTH];

  // Write port; out-of-range addresses are ignored.
  always_ff @(posedge clock) begin
    if (wr_en && (wr_addr < 7'(DDRAM_DEPTH))) mem[wr_addr] <= wr_data;
  end

  // Registered display-side read; out-of-range cells read as blank.
  always_ff @(posedge clock) begin
    rd_data <= (rd_addr < 7'(DDRAM_DEPTH)) ? mem[rd_addr] : CHAR_SPACE;
  end

  assign ar_data = (ar_addr < 7'(DDRAM_DEPTH)) ? mem[ar_addr] : CHAR_SPACE;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Device side of the 8-bit HD44780 parallel bus with a 2x40 DDRAM mirror.
// Optional bus readback (busy flag / AC / DDRAM) is enabled by defining
// LCD_READBACK_EN.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_CYCLES  = 4,
  parameter int unsigned HOME_CYCLES = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic       rd_line,
  input  logic [5:0] rd_col,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       busy,
  output logic       char_wr,
  output logic       overrun
);

`ifdef LCD_READBACK_EN
  localparam bit ReadbackEn = 1'b1;
`else
  localparam bit ReadbackEn = 1'b0;
`endif

  localparam int unsigned MaxCycles = (HOME_CYCLES > CMD_CYCLES) ? HOME_CYCLES : CMD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  // {en, rs, rw, data} through the synchronizer chain.
  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic                         en_prev_q;
  logic [10:0]                  sync_last;
  logic                         en_s, rs_s, rw_s, en_fall, strobe_wr, strobe_rd;

  lcd_state_e      state_q;
  logic [6:0]      clr_idx_q;
  logic [CntW-1:0] cnt_q;
  logic [6:0]      ac_q;
  logic            id_q, shift_q, disp_q, curs_q, blink_q, n_q, overrun_q, char_wr_q;
  logic            cmd_rs_q, cmd_rw_q;
  logic [7:0]      cmd_data_q;

  logic       wr_en;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data, ar_data;
  logic       unused_shift, unused_ar_data;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign en_s      = sync_last[10];
  assign rs_s      = sync_last[9];
  assign rw_s      = sync_last[8];
  assign en_fall   = en_prev_q & ~en_s;
  assign strobe_wr = en_fall & ~rw_s;
  assign strobe_rd = en_fall & rw_s & ReadbackEn;

  // Bring the asynchronous bus into the clock domain and keep the previous EN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      en_prev_q <= en_s;
    end
  end

  // Main FSM: power-on/instruction clear, strobe capture, decode, busy timing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StClear;
      clr_idx_q  <= '0;
      cnt_q      <= '0;
      ac_q       <= '0;
      id_q       <= 1'b1;
      shift_q    <= 1'b0;
      disp_q     <= 1'b0;
      curs_q     <= 1'b0;
      blink_q    <= 1'b0;
      n_q        <= 1'b0;
      overrun_q  <= 1'b0;
      char_wr_q  <= 1'b0;
      cmd_rs_q   <= 1'b0;
      cmd_rw_q   <= 1'b0;
      cmd_data_q <= '0;
    end else begin
      char_wr_q <= 1'b0;
      // Writes arriving while busy are dropped; reads (busy poll) are not.
      if (strobe_wr && (state_q != StIdle)) overrun_q <= 1'b1;
      unique case (state_q)
        StClear: begin
          if (clr_idx_q == 7'(DDRAM_DEPTH - 1)) begin
            clr_idx_q <= '0;
            state_q   <= StIdle;
          end else begin
            clr_idx_q <= clr_idx_q + 7'd1;
          end
        end
        StIdle: begin
          if (strobe_wr || strobe_rd) begin
            cmd_rs_q   <= rs_s;
            cmd_rw_q   <= rw_s;
            cmd_data_q <= sync_last[7:0];
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          state_q <= StBusy;
          cnt_q   <= CntW'(CMD_CYCLES - 1);
          if (cmd_rw_q) begin
            state_q <= StIdle;
            if (cmd_rs_q) ac_q <= ac_step(ac_q, id_q);
          end else if (cmd_rs_q) begin
            if (ac_valid(ac_q)) begin
              char_wr_q <= 1'b1;
              ac_q      <= ac_step(ac_q, id_q);
            end else begin
              overrun_q <= 1'b1;
              state_q   <= StIdle;
            end
          end else if (|(cmd_data_q & OP_SET_DDRAM)) begin
            ac_q <= cmd_data_q[6:0];
          end else if (|(cmd_data_q & OP_SET_CGRAM)) begin
            // CGRAM is not modelled; the write is accepted and discarded.
          end else if (|(cmd_data_q & OP_FUNC_SET)) begin
            n_q <= cmd_data_q[3];
            if (!cmd_data_q[4]) overrun_q <= 1'b1;
          end else if (|(cmd_data_q & OP_SHIFT)) begin
            if (!cmd_data_q[3]) ac_q <= ac_step(ac_q, cmd_data_q[2]);
          end else if (|(cmd_data_q & OP_DISPLAY)) begin
            disp_q  <= cmd_data_q[2];
            curs_q  <= cmd_data_q[1];
            blink_q <= cmd_data_q[0];
          end else if (|(cmd_data_q & OP_ENTRY)) begin
            id_q    <= cmd_data_q[1];
            shift_q <= cmd_data_q[0];
          end else if (|(cmd_data_q & OP_HOME)) begin
            ac_q  <= '0;
            cnt_q <= CntW'(HOME_CYCLES - 1);
          end else if (|(cmd_data_q & OP_CLEAR)) begin
            ac_q    <= '0;
            id_q    <= 1'b1;
            state_q <= StClear;
          end
        end
        StBusy: begin
          if (cnt_q == '0) state_q <= StIdle;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // DDRAM write source: clear sweep or a decoded data write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_idx_q;
    wr_data = CHAR_SPACE;
    if (state_q == StClear) begin
      wr_en = 1'b1;
    end else if ((state_q == StDecode) && !cmd_rw_q && cmd_rs_q && ac_valid(ac_q)) begin
      wr_en   = 1'b1;
      wr_addr = ac_index(ac_q);
      wr_data = cmd_data_q;
    end
  end

  assign rd_addr = rd_line ? (7'(LINE_LEN) + {1'b0, rd_col}) : {1'b0, rd_col};

  lcd_ddram u_ddram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_char),
    .ar_addr (ac_index(ac_q)),
    .ar_data (ar_data)
  );

  assign cursor_addr  = ac_q;
  assign display_on   = disp_q;
  assign cursor_on    = curs_q;
  assign blink_on     = blink_q;
  assign two_line     = n_q;
  assign busy         = (state_q != StIdle);
  assign char_wr      = char_wr_q;
  assign overrun      = overrun_q;
  // Entry-mode S is stored for completeness; display shift is not modelled.
  assign unused_shift = shift_q;

`ifdef LCD_READBACK_EN
  assign lcd_data_oe    = en_s & rw_s;
  assign lcd_data_out   = rs_s ? ar_data : {busy, ac_q};
  assign unused_ar_data = 1'b0;
`else
  assign lcd_data_oe    = 1'b0;
  assign lcd_data_out   = 8'h00;
  assign unused_ar_data = ^ar_data;
`endif

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed self-checking bench for lcd_hd44780_responder.
module tb_lcd_hd44780_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic       rd_line;
  logic [5:0] rd_col;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, two_line, busy, char_wr, overrun;

  int         total = 0;
  int         bad   = 0;
  int         pulses = 0;
  int         p0;
  int         n;
  logic [7:0] v;
  logic       mid_oe;
  logic [7:0] mid_out;

  lcd_hd44780_responder dut (
    .clock        (clock),
    .reset        (reset),
    .lcd_en       (lcd_en),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_data     (lcd_data),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .rd_line      (rd_line),
    .rd_col       (rd_col),
    .rd_char      (rd_char),
    .cursor_addr  (cursor_addr),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .two_line     (two_line),
    .busy         (busy),
    .char_wr      (char_wr),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (char_wr) pulses++;

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Drive one EN pulse; sample the readback pins just before EN falls.
  task automatic strobe(input logic s_rs, input logic s_rw, input logic [7:0] s_d);
    @(negedge clock);
    lcd_rs   = s_rs;
    lcd_rw   = s_rw;
    lcd_data = s_d;
    lcd_en   = 1'b1;
    repeat (3) @(negedge clock);
    mid_oe  = lcd_data_oe;
    mid_out = lcd_data_out;
    lcd_en  = 1'b0;
  endtask

  task automatic wait_rise();
    int k = 0;
    while (!busy && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    check_eq("busy_rise", int'(busy), 1);
  endtask

  // Count posedges until busy drops.
  task automatic wait_fall(output int cnt);
    cnt = 0;
    do begin
      @(posedge clock); #1;
      cnt++;
    end while (busy && cnt < 300);
  endtask

  task automatic op(input logic s_rs, input logic [7:0] s_d, output int cnt);
    strobe(s_rs, 1'b0, s_d);
    wait_rise();
    wait_fall(cnt);
  endtask

  task automatic read_cell(input logic l, input logic [5:0] c, output logic [7:0] val);
    rd_line = l;
    rd_col  = c;
    @(posedge clock); #1;
    val = rd_char;
  endtask

  initial begin
    reset = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
    rd_line = 1'b0; rd_col = 6'd0;
    repeat (3) @(posedge clock); #1;

    // 1: reset values, power-on clear length and blank DDRAM
    check_eq("rst_busy", int'(busy), 1);
    check_eq("rst_overrun", int'(overrun), 0);
    check_eq("rst_char_wr", int'(char_wr), 0);
    check_eq("rst_ac", int'(cursor_addr), 0);
    check_eq("rst_dcbn", int'({display_on, cursor_on, blink_on, two_line}), 0);
    check_eq("rst_oe", int'(lcd_data_oe), 0);
    @(negedge clock); reset = 1'b0;
    wait_fall(n);
    check_eq("init_clear_len", n, 80);
    for (int i = 0; i < 80; i++) begin
      read_cell(i >= 40, 6'((i >= 40) ? i - 40 : i), v);
      check_eq($sformatf("blank_%0d", i), int'(v), 8'h20);
    end

    // 2: function set, display control, clear, entry mode
    op(1'b0, 8'h38, n);
    check_eq("cmd_len", n, 5);
    check_eq("two_line", int'(two_line), 1);
    op(1'b0, 8'h0C, n);
    check_eq("disp_cb", int'({display_on, cursor_on, blink_on}), 3'b100);
    op(1'b0, 8'h85, n);
    check_eq("ac_set", int'(cursor_addr), 7'h05);
    op(1'b0, 8'h01, n);
    check_eq("clear_len", n, 81);
    check_eq("clear_ac", int'(cursor_addr), 0);
    op(1'b0, 8'h06, n);

    // 3: write on line 2
    op(1'b0, 8'hC0, n);
    check_eq("ac_line2", int'(cursor_addr), 7'h40);
    p0 = pulses;
    op(1'b1, 8'h41, n);
    check_eq("char_wr_one", pulses - p0, 1);
    check_eq("ac_after_wr", int'(cursor_addr), 7'h41);
    read_cell(1'b1, 6'd0, v);
    check_eq("rd_1_0", int'(v), 8'h41);

    // 4: AC wrap on writes and cursor shift
    op(1'b0, 8'hA7, n);
    op(1'b1, 8'h5A, n);
    check_eq("wrap_27_40", int'(cursor_addr), 7'h40);
    op(1'b0, 8'h10, n);
    check_eq("shift_left", int'(cursor_addr), 7'h27);
    op(1'b0, 8'h14, n);
    check_eq("shift_right", int'(cursor_addr), 7'h40);
    op(1'b0, 8'hE7, n);
    op(1'b1, 8'h5A, n);
    check_eq("wrap_67_00", int'(cursor_addr), 7'h00);
    op(1'b0, 8'h04, n);
    op(1'b1, 8'h5B, n);
    check_eq("wrap_00_67", int'(cursor_addr), 7'h67);
    read_cell(1'b0, 6'd39, v);
    check_eq("rd_0_39", int'(v), 8'h5A);
    read_cell(1'b1, 6'd39, v);
    check_eq("rd_1_39", int'(v), 8'h5A);
    read_cell(1'b0, 6'd0, v);
    check_eq("rd_0_0", int'(v), 8'h5B);
    op(1'b0, 8'h06, n);
    op(1'b0, 8'h02, n);
    check_eq("home_len", n, 17);
    check_eq("home_ac", int'(cursor_addr), 0);

    // 5: overrun from a write while busy, then from an invalid AC
    check_eq("no_overrun_yet", int'(overrun), 0);
    p0 = pulses;
    strobe(1'b0, 1'b0, 8'h02);
    wait_rise();
    strobe(1'b1, 1'b0, 8'h42);
    wait_fall(n);
    check_eq("busy_wr_overrun", int'(overrun), 1);
    check_eq("busy_wr_no_pulse", pulses - p0, 0);
    read_cell(1'b0, 6'd0, v);
    check_eq("busy_wr_dropped", int'(v), 8'h5B);
    op(1'b0, 8'hB0, n);
    p0 = pulses;
    op(1'b1, 8'h42, n);
    check_eq("bad_ac_kept", int'(cursor_addr), 7'h30);
    check_eq("bad_ac_no_pulse", pulses - p0, 0);
    op(1'b0, 8'h80, n);
    check_eq("overrun_sticky", int'(overrun), 1);

    // 6: reset in the middle of a clear
    strobe(1'b0, 1'b0, 8'h01);
    wait_rise();
    repeat (30) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", int'(busy), 1);
    check_eq("mid_rst_overrun", int'(overrun), 0);
    check_eq("mid_rst_dcbn", int'({display_on, cursor_on, blink_on, two_line}), 0);
    check_eq("mid_rst_ac", int'(cursor_addr), 0);
    @(negedge clock); reset = 1'b0;
    wait_fall(n);
    check_eq("reclear_len", n, 80);
    read_cell(1'b1, 6'd0, v);
    check_eq("reclear_1_0", int'(v), 8'h20);

`ifdef LCD_READBACK_EN
    strobe(1'b0, 1'b0, 8'h02);
    wait_rise();
    strobe(1'b0, 1'b1, 8'h00);
    check_eq("rb_oe", int'(mid_oe), 1);
    check_eq("rb_busy_flag", int'(mid_out[7]), 1);
    wait_fall(n);
    check_eq("rb_no_overrun", int'(overrun), 0);
`else
    strobe(1'b1, 1'b1, 8'h00);
    check_eq("rd_strobe_oe", int'(mid_oe), 0);
    check_eq("rd_strobe_out", int'(mid_out), 0);
    repeat (10) @(posedge clock); #1;
    check_eq("rd_strobe_idle", int'(busy), 0);
    check_eq("rd_strobe_no_overrun", int'(overrun), 0);
    check_eq("rd_strobe_ac", int'(cursor_addr), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
